// File: rtl/bt_tx_arbiter.sv
// Round-robin arbiter sharing one Bluetooth UART transmitter between NUM_REQ byte producers.
// Optional frame lock (whole frame per grant) enabled by defining BT_TX_ARB_FRAME_LOCK_EN.
module bt_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BUSY_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 16,
  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_send_o,
  input  logic                 tx_busy_i,
  output logic [GW-1:0]        grant_id_o,
  output logic                 arb_idle_o,
  output logic                 err_timeout_o,
  output logic [CNT_W-1:0]     sent_count_o
);

  typedef enum logic [1:0] {ARB, ISSUE, WAIT_HI, WAIT_LO} state_e;

  state_e             state_q, state_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_send_q, tx_send_d;
  logic [GW-1:0]      grant_id_q, grant_id_d;
  logic               arb_idle_q, arb_idle_d;
  logic               err_timeout_q, err_timeout_d;
  logic [CNT_W-1:0]   sent_count_q, sent_count_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               lock_q, lock_d;
  logic               last_q, last_d;

  logic [NUM_REQ-1:0] cand;
  logic               found;
  logic [GW-1:0]      win;
  int unsigned        idx;

`ifndef BT_TX_ARB_FRAME_LOCK_EN
  logic unused_last;
  assign unused_last = ^req_last_i;
`endif

  // Wrapping search from the requester after rr_ptr; a locked frame narrows the candidates to its owner.
  always_comb begin
    cand  = lock_q ? (req_valid_i & (NUM_REQ'(1) << grant_id_q)) : req_valid_i;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(rr_ptr_q) + off) % NUM_REQ;
      if (!found && cand[GW'(idx)]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    req_ready_d   = '0;
    tx_data_d     = tx_data_q;
    tx_send_d     = 1'b0;
    grant_id_d    = grant_id_q;
    err_timeout_d = 1'b0;
    sent_count_d  = sent_count_q;
    tmo_d         = tmo_q;
    lock_d        = lock_q;
    last_d        = last_q;
    unique case (state_q)
      ARB: begin
        if (found && !tx_busy_i) begin
          state_d     = ISSUE;
          req_ready_d = NUM_REQ'(1) << win;
          tx_data_d   = req_data_i[8*32'(win) +: 8];
          grant_id_d  = win;
`ifdef BT_TX_ARB_FRAME_LOCK_EN
          last_d      = req_last_i[win];
`else
          last_d      = 1'b1;
`endif
        end
      end
      ISSUE: begin
        tx_send_d = 1'b1;
        tmo_d     = '0;
        state_d   = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy_i) begin
          state_d = WAIT_LO;
        end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never acknowledged: drop the byte and any frame lock.
          err_timeout_d = 1'b1;
          rr_ptr_d      = grant_id_q;
          lock_d        = 1'b0;
          state_d       = ARB;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!tx_busy_i) begin
          sent_count_d = sent_count_q + 1'b1;
          lock_d       = !last_q;
          if (last_q) rr_ptr_d = grant_id_q;
          state_d      = ARB;
        end
      end
      default: state_d = ARB;
    endcase
    arb_idle_d = (state_d == ARB) && !lock_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ARB;
      rr_ptr_q      <= GW'(NUM_REQ - 1);
      req_ready_q   <= '0;
      tx_data_q     <= '0;
      tx_send_q     <= 1'b0;
      grant_id_q    <= '0;
      arb_idle_q    <= 1'b1;
      err_timeout_q <= 1'b0;
      sent_count_q  <= '0;
      tmo_q         <= '0;
      lock_q        <= 1'b0;
      last_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      req_ready_q   <= req_ready_d;
      tx_data_q     <= tx_data_d;
      tx_send_q     <= tx_send_d;
      grant_id_q    <= grant_id_d;
      arb_idle_q    <= arb_idle_d;
      err_timeout_q <= err_timeout_d;
      sent_count_q  <= sent_count_d;
      tmo_q         <= tmo_d;
      lock_q        <= lock_d;
      last_q        <= last_d;
    end
  end

  assign req_ready_o   = req_ready_q;
  assign tx_data_o     = tx_data_q;
  assign tx_send_o     = tx_send_q;
  assign grant_id_o    = grant_id_q;
  assign arb_idle_o    = arb_idle_q;
  assign err_timeout_o = err_timeout_q;
  assign sent_count_o  = sent_count_q;

endmodule

// File: tb/tb_bt_tx_arbiter.sv
// Directed self-checking bench for bt_tx_arbiter (NUM_REQ=4, BUSY_TIMEOUT=64, CNT_W=4).
// A behavioural transmitter raises busy one cycle after tx_send and drops it some cycles later.
module tb_bt_tx_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [3:0]  req_valid_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_last_i;
  logic [3:0]  req_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_send_o;
  logic        tx_busy_i;
  logic [1:0]  grant_id_o;
  logic        arb_idle_o;
  logic        err_timeout_o;
  logic [3:0]  sent_count_o;

  int tests = 0;
  int fails = 0;
  logic busy_en;
  int   busy_cnt;

  bt_tx_arbiter #(.NUM_REQ(4), .BUSY_TIMEOUT(64), .CNT_W(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .tx_data_o(tx_data_o), .tx_send_o(tx_send_o),
    .tx_busy_i(tx_busy_i), .grant_id_o(grant_id_o), .arb_idle_o(arb_idle_o),
    .err_timeout_o(err_timeout_o), .sent_count_o(sent_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Transmitter model, reset by the same signal as the arbiter.
  always @(posedge clk_i) begin
    if (reset_i) begin
      tx_busy_i <= 1'b0;
      busy_cnt  <= 0;
    end else if (tx_send_o && busy_en) begin
      tx_busy_i <= 1'b1;
      busy_cnt  <= 10;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) tx_busy_i <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; req_valid_i = '0; busy_en = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (req_ready_o != '0) ok = 1'b1;
    end
  endtask

  task automatic wait_send(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (tx_send_o) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (arb_idle_o) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (req_ready_o !== 4'h0) begin fails++; $display("FAIL reset_ready: got %h expected 0", req_ready_o); end
    tests++; if (tx_send_o !== 1'b0) begin fails++; $display("FAIL reset_send: got %b expected 0", tx_send_o); end
    tests++; if (tx_data_o !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", tx_data_o); end
    tests++; if (grant_id_o !== 2'd0) begin fails++; $display("FAIL reset_grant: got %0d expected 0", grant_id_o); end
    tests++; if (arb_idle_o !== 1'b1) begin fails++; $display("FAIL reset_idle: got %b expected 1", arb_idle_o); end
    tests++; if (err_timeout_o !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err_timeout_o); end
    tests++; if (sent_count_o !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", sent_count_o); end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    req_data_i = 32'h000000A5; req_last_i = 4'hF; req_valid_i = 4'b0001;
    wait_ready(ok);
    tests++; if (!ok || req_ready_o !== 4'b0001) begin fails++; $display("FAIL single_ready: got %b expected 0001", req_ready_o); end
    req_valid_i = '0;
    tick();
    tests++; if (tx_send_o !== 1'b1) begin fails++; $display("FAIL single_send: got %b expected 1", tx_send_o); end
    tests++; if (tx_data_o !== 8'hA5) begin fails++; $display("FAIL single_data: got %h expected a5", tx_data_o); end
    wait_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_idle: got 0 expected 1"); end
    tests++; if (sent_count_o !== 4'd1) begin fails++; $display("FAIL single_count: got %0d expected 1", sent_count_o); end
    tests++; if (tx_data_o !== 8'hA5) begin fails++; $display("FAIL single_data_hold: got %h expected a5", tx_data_o); end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    req_data_i = 32'h13121110; req_last_i = 4'hF; req_valid_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      wait_send(ok);
      if (i == 7) req_valid_i = '0;
      tests++; if (!ok || tx_data_o !== 8'h10 + 8'(i % 4)) begin fails++; $display("FAIL rr_data%0d: got %h expected %h", i, tx_data_o, 8'h10 + 8'(i % 4)); end
      tests++; if (grant_id_o !== 2'(i % 4)) begin fails++; $display("FAIL rr_grant%0d: got %0d expected %0d", i, grant_id_o, i % 4); end
    end
    wait_idle(ok);
    tests++; if (!ok || sent_count_o !== 4'd8) begin fails++; $display("FAIL rr_count: got %0d expected 8", sent_count_o); end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    do_reset();
    busy_en = 1'b0;
    req_data_i = 32'h00000055; req_last_i = 4'hF; req_valid_i = 4'b0001;
    wait_ready(ok);
    req_valid_i = '0;
    wait_send(ok);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick(); n++;
      if (err_timeout_o) break;
    end
    tests++; if (!err_timeout_o || n != 64) begin fails++; $display("FAIL timeout_delay: got %0d cycles expected 64", n); end
    tests++; if (sent_count_o !== 4'd0) begin fails++; $display("FAIL timeout_count: got %0d expected 0", sent_count_o); end
    tests++; if (arb_idle_o !== 1'b1) begin fails++; $display("FAIL timeout_idle: got %b expected 1", arb_idle_o); end
    tick();
    tests++; if (err_timeout_o !== 1'b0) begin fails++; $display("FAIL timeout_pulse: got %b expected 0", err_timeout_o); end
    busy_en = 1'b1;
    req_data_i = 32'h00006655; req_valid_i = 4'b0011;
    wait_ready(ok);
    tests++; if (!ok || req_ready_o !== 4'b0010) begin fails++; $display("FAIL timeout_next: got %b expected 0010", req_ready_o); end
    req_valid_i = '0;
    wait_idle(ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    req_data_i = 32'h00004140; req_last_i = 4'hF; req_valid_i = 4'b0001;
    wait_ready(ok); req_valid_i = '0;
    wait_idle(ok);
    req_valid_i = 4'b0010;
    wait_ready(ok); req_valid_i = '0;
    wait_send(ok);
    tick(); tick(); tick();
    reset_i = 1'b1;
    tick();
    tests++; if (req_ready_o !== 4'h0 || tx_send_o !== 1'b0 || err_timeout_o !== 1'b0) begin fails++; $display("FAIL mid_reset_strobes: got %b/%b/%b expected 0000/0/0", req_ready_o, tx_send_o, err_timeout_o); end
    tests++; if (tx_data_o !== 8'h00 || grant_id_o !== 2'd0) begin fails++; $display("FAIL mid_reset_data: got %h/%0d expected 00/0", tx_data_o, grant_id_o); end
    tests++; if (arb_idle_o !== 1'b1 || sent_count_o !== 4'd0) begin fails++; $display("FAIL mid_reset_idle: got %b/%0d expected 1/0", arb_idle_o, sent_count_o); end
    reset_i = 1'b0;
    req_valid_i = 4'b0011;
    wait_ready(ok);
    tests++; if (!ok || req_ready_o !== 4'b0001) begin fails++; $display("FAIL mid_reset_first: got %b expected 0001", req_ready_o); end
    req_valid_i = '0;
    wait_idle(ok);
  endtask

  task automatic test_frame();
    bit ok;
    int n, idx2;
    logic [1:0] exp_g [5];
`ifdef BT_TX_ARB_FRAME_LOCK_EN
    exp_g = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd1};
`else
    exp_g = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
`endif
    do_reset();
    n = 0; idx2 = 0;
    req_data_i = 32'h00302100; req_last_i = 4'b0010; req_valid_i = 4'b0110;
    for (int c = 0; c < 600 && n < 5; c++) begin
      tick();
      if (req_ready_o[2]) begin
        idx2++;
        if (idx2 == 3) req_valid_i[2] = 1'b0;
        req_data_i[23:16] = 8'h30 + 8'(idx2);
        req_last_i[2] = (idx2 == 2);
      end
      if (tx_send_o) begin
        tests++; if (grant_id_o !== exp_g[n]) begin fails++; $display("FAIL frame_grant%0d: got %0d expected %0d", n, grant_id_o, exp_g[n]); end
        n++;
      end
    end
    tests++; if (n != 5) begin fails++; $display("FAIL frame_sends: got %0d expected 5", n); end
    req_valid_i = '0;
    wait_idle(ok);
  endtask

  task automatic test_wrap();
    bit ok;
    int n;
    do_reset();
    req_data_i = 32'h0000007E; req_last_i = 4'hF; req_valid_i = 4'b0001;
    n = 0;
    for (int i = 0; i < 17; i++) begin
      wait_send(ok);
      if (ok) n++;
    end
    req_valid_i = '0;
    wait_idle(ok);
    tests++; if (n != 17 || !ok || sent_count_o !== 4'd1) begin fails++; $display("FAIL wrap_count: got %0d after %0d sends expected 1", sent_count_o, n); end
  endtask

  initial begin
    reset_i = 1'b1; req_valid_i = '0; req_data_i = '0; req_last_i = '0; busy_en = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_frame();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
